conv_window_gen: RTL
====================

Name: conv_window_gen

Overview:
- Streaming 3x3 window generator; the producer side of the 3x3 convolution datapath.
- Accepts a raster-order pixel stream (row-major, one pixel per handshake) of a fixed IMG_W x IMG_H frame.
- Emits every complete 3x3 neighbourhood (valid convolution, no padding) as nine parallel words, ordered to drive data0..data8 of the conv unit directly.
- Sits between the pixel source/DMA and the convolution multiply-add tree.

Parameters:
- DATA_W, 16, pixel width in bits (matches 16-bit conv data inputs).
- IMG_W, 8, frame width in pixels (>=3).
- IMG_H, 8, frame height in pixels (>=3).

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  pixel available
- in_ready  output  1  block can accept pixel
- in_data  input  DATA_W  pixel value
- out_valid  output  1  window available
- out_ready  input  1  consumer accepts window
- win0..win8  output  DATA_W each  window, row-major; win0 = top-left, win4 = centre, win8 = bottom-right
- frame_done  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Accept: in_valid && in_ready on a rising edge. Emit: out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a single output register with pass-through backpressure and no bubble at full rate.
- Counters col (0..IMG_W-1) and row (0..IMG_H-1) track the position of the next accepted pixel.
  - col advances on each accept.
  - At IMG_W-1, col wraps to 0 and row increments.
  - At (IMG_H-1, IMG_W-1), both wrap to 0.
- Two line buffers, lb1 (row r-2) and lb0 (row r-1), each IMG_W x DATA_W. On accept of pixel p at (row, col):
  - The 3x3 window register shifts one column left.
  - The new right column is {lb1[col], lb0[col], p}, top to bottom.
  - Then lb1[col] <= lb0[col] and lb0[col] <= p.
- Window valid condition: the accept is at row >= 2 and col >= 2. In that case the next edge sets out_valid=1 and loads win0..win8.
  - win0 = pixel(row-2, col-2); win8 = pixel(row, col).
  - Latency: 1 cycle from accept to out_valid.
- On an emit with no new valid window in the same cycle, out_valid clears.
- Simultaneous emit and new window in the same cycle: out_valid stays 1 and win* update.
- While out_valid && !out_ready: win* and out_valid hold stable, and in_ready=0.
- Window count per frame is (IMG_W-2)*(IMG_H-2). Row-edge accepts (col < 2) produce no output but still shift the window register.
- Back-to-back frames need no gap. Stale line-buffer contents from the previous frame are never emitted because of the row >= 2 gating.
- frame_done pulses 1 on the cycle after the accept at (IMG_H-1, IMG_W-1).
- Reset (asynchronous, any time including mid-frame):
  - col=0, row=0, out_valid=0, frame_done=0, win0..win8=0.
  - Line buffers need no reset.
  - in_ready is 1 as soon as reset deasserts.
- No arithmetic on pixel values; widths pass through unchanged.

Optional Feature:
- Macro CONV_WIN_LAST_EN.
- Defined: adds output port out_last (1 bit, reset 0), loaded with the window. It is 1 only for the window produced by the accept at (IMG_H-1, IMG_W-1), and is held stable under backpressure like win*.
- Undefined: port absent; all other behaviour identical.

Decomposition:
- Package conv_pkg: DATA_W default, WIN_SIZE=9, window index constants (WIN_TL=0, WIN_C=4, WIN_BR=8), and a win_t unpacked-array typedef of 9 DATA_W words. The conv unit shares this package.
- Sub-module conv_line_buf: one IMG_W-deep, DATA_W-wide buffer with read and write at the same index. It is instantiated twice, lb0 and lb1.
- Top level keeps the counters, the window shift register and the handshake logic.

Test Plan:
- Nominal: IMG_W=4, IMG_H=4, pixels 0..15, out_ready=1.
  - out_valid first rises 1 cycle after pixel 10 is accepted, with win = 0,1,2,4,5,6,8,9,10.
  - Exactly 4 windows; the last is 5,6,7,9,10,11,13,14,15.
  - frame_done pulses once, after pixel 15.
- Backpressure: same frame, out_ready=0 for 5 cycles at the first window.
  - in_ready=0 for those cycles; win stays 0,1,2,4,5,6,8,9,10.
  - Resumes with no loss or duplication.
- Back-to-back frames: two 4x4 frames, the second with pixels 100..115 and no idle cycle.
  - 8 windows total.
  - The first window of frame 2 is 100,101,102,104,105,106,108,109,110, with no frame-1 data.
- Reset mid-frame: assert rst_n=0 after pixel 7.
  - out_valid=0 and win*=0 immediately.
  - A fresh 0..15 frame then reproduces the nominal sequence exactly.
- Random in_valid/out_ready (50% each), IMG_W=8, IMG_H=5.
  - 18 windows.
  - The scoreboard matches a reference model of the 3x3 neighbourhood in raster order.
- With CONV_WIN_LAST_EN, nominal 4x4 frame: out_last=1 only with window 5,6,7,9,10,11,13,14,15, held during backpressure.

Source files
------------

// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 convolution datapath (window generator and
// conv unit).
//   CONV_DATA_W        : default pixel / conv data width
//   WIN_DIM, WIN_SIZE  : window is WIN_DIM x WIN_DIM = WIN_SIZE words
//   WIN_TL/WIN_C/WIN_BR: top-left, centre and bottom-right word indices
//   win_t              : nine-word window, row-major
//   win_idx()          : (row, col) inside the window -> word index
// ---------------------------------------------------------------------------
package conv_pkg;

   localparam int CONV_DATA_W = 16;
   localparam int WIN_DIM     = 3;
   localparam int WIN_SIZE    = WIN_DIM * WIN_DIM;

   localparam int WIN_TL = 0;
   localparam int WIN_C  = 4;
   localparam int WIN_BR = 8;

   typedef logic [CONV_DATA_W-1:0] win_t [WIN_SIZE];

   function automatic int win_idx(input int r, input int c);
      return r * WIN_DIM + c;
   endfunction

endpackage

// File: rtl/conv_line_buf.sv
// ---------------------------------------------------------------------------
// conv_line_buf
// One image line of storage. Read and write share one index: the read
// returns the value stored before this cycle's write (the pixel one row up),
// and the write replaces it with the pixel of the current row.
// Ports:
//   clk   : clock
//   we    : write enable (one pixel accepted)
//   addr  : column index
//   wdata : value written at addr
//   rdata : current contents at addr (combinational read)
// No reset: contents are only ever used after being rewritten in the frame.
// ---------------------------------------------------------------------------
module conv_line_buf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Same-index read must see the old value, so the read is not registered.
   assign rdata = mem[addr];

endmodule

// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
// Streaming 3x3 window generator. Takes a raster-order pixel stream of a
// fixed IMG_W x IMG_H frame and emits every complete 3x3 neighbourhood
// (no padding) as nine parallel words for the conv unit.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : pixel handshake, in_data = pixel
//   out_valid/out_ready  : window handshake
//   win0..win8           : window, row-major (win0 top-left, win8 bottom-right)
//   frame_done           : one-cycle pulse after the last pixel is accepted
//   out_last             : (only with CONV_WIN_LAST_EN) marks the final
//                          window of a frame, travels with win*
// Optional feature macro: CONV_WIN_LAST_EN
// ---------------------------------------------------------------------------
module conv_window_gen
   import conv_pkg::*;
#(
   parameter int DATA_W = CONV_DATA_W,
   parameter int IMG_W  = 8,
   parameter int IMG_H  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] win0,
   output logic [DATA_W-1:0] win1,
   output logic [DATA_W-1:0] win2,
   output logic [DATA_W-1:0] win3,
   output logic [DATA_W-1:0] win4,
   output logic [DATA_W-1:0] win5,
   output logic [DATA_W-1:0] win6,
   output logic [DATA_W-1:0] win7,
   output logic [DATA_W-1:0] win8,
   output logic              frame_done
`ifdef CONV_WIN_LAST_EN
   ,
   output logic              out_last
`endif
);

   localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   logic [COL_W-1:0]  col_reg;
   logic [ROW_W-1:0]  row_reg;
   logic              out_valid_reg;
   logic              frame_done_reg;
   logic [DATA_W-1:0] shift_reg  [WIN_SIZE];
   logic [DATA_W-1:0] shift_next [WIN_SIZE];
   logic [DATA_W-1:0] win_reg    [WIN_SIZE];
   logic [DATA_W-1:0] new_col    [WIN_DIM];
   logic [DATA_W-1:0] lb0_rdata;
   logic [DATA_W-1:0] lb1_rdata;
   logic              accept;
   logic              win_hit;
   logic              col_end;
   logic              last_pix;

   // Single output register: a waiting window blocks input unless it is
   // being taken this very cycle.
   assign in_ready = !out_valid_reg || out_ready;
   assign accept   = in_valid && in_ready;
   assign col_end  = (col_reg == COL_LAST);
   assign last_pix = col_end && (row_reg == ROW_LAST);
   // Rows 0/1 of a frame never form a window, which also masks any stale
   // line-buffer contents left over from the previous frame.
   assign win_hit  = accept && (row_reg >= ROW_W'(2)) && (col_reg >= COL_W'(2));

   // lb0 holds row r-1, lb1 holds row r-2; lb1 is fed by lb0's old value.
   conv_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_W)
   ) u_lb0 (
      .clk   (clk),
      .we    (accept),
      .addr  (col_reg),
      .wdata (in_data),
      .rdata (lb0_rdata)
   );

   conv_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_W)
   ) u_lb1 (
      .clk   (clk),
      .we    (accept),
      .addr  (col_reg),
      .wdata (lb0_rdata),
      .rdata (lb1_rdata)
   );

   assign new_col[0] = lb1_rdata;
   assign new_col[1] = lb0_rdata;
   assign new_col[2] = in_data;

   // Shift every window row one column left and append the new column.
   generate
      for (genvar gi = 0; gi < WIN_DIM; gi++) begin : g_row
         assign shift_next[win_idx(gi, 0)] = shift_reg[win_idx(gi, 1)];
         assign shift_next[win_idx(gi, 1)] = shift_reg[win_idx(gi, 2)];
         assign shift_next[win_idx(gi, 2)] = new_col[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_reg        <= '0;
         row_reg        <= '0;
         out_valid_reg  <= 1'b0;
         frame_done_reg <= 1'b0;
         for (int i = 0; i < WIN_SIZE; i++) begin
            shift_reg[i] <= '0;
            win_reg[i]   <= '0;
         end
      end else begin
         frame_done_reg <= accept && last_pix;

         if (accept) begin
            for (int i = 0; i < WIN_SIZE; i++) begin
               shift_reg[i] <= shift_next[i];
            end
            if (col_end) begin
               col_reg <= '0;
               row_reg <= (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
               col_reg <= col_reg + 1'b1;
            end
         end

         if (win_hit) begin
            out_valid_reg <= 1'b1;
            for (int i = 0; i < WIN_SIZE; i++) begin
               win_reg[i] <= shift_next[i];
            end
         end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
         end
      end
   end

`ifdef CONV_WIN_LAST_EN
   logic out_last_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_last_reg <= 1'b0;
      end else if (win_hit) begin
         out_last_reg <= last_pix;
      end
   end

   assign out_last = out_last_reg;
`endif

   assign out_valid  = out_valid_reg;
   assign frame_done = frame_done_reg;
   assign win0 = win_reg[WIN_TL];
   assign win1 = win_reg[1];
   assign win2 = win_reg[2];
   assign win3 = win_reg[3];
   assign win4 = win_reg[WIN_C];
   assign win5 = win_reg[5];
   assign win6 = win_reg[6];
   assign win7 = win_reg[7];
   assign win8 = win_reg[WIN_BR];

endmodule
